// File: rtl/cycle_ctrl_if.sv
// rtl/cycle_ctrl_if.sv - control sequencer <-> datapath signal bundle
interface cycle_ctrl_if #(parameter int CNT_W = 16);
  logic             start;
  logic [8:0]       mach_code;
  logic             zero_q;
  logic [8:0]       ir;
  logic             pc_en;
  logic             relj;
  logic             reg_wr;
  logic             mem_rd;
  logic             mem_wr;
  logic             flag_en;
  logic             sc_clr;
  logic             sc_en;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] instr_cnt;

  modport master (
    input  start, mach_code, zero_q,
    output ir, pc_en, relj, reg_wr, mem_rd, mem_wr, flag_en, sc_clr, sc_en,
           busy, done, instr_cnt
  );

  modport slave (
    output start, mach_code, zero_q,
    input  ir, pc_en, relj, reg_wr, mem_rd, mem_wr, flag_en, sc_clr, sc_en,
           busy, done, instr_cnt
  );
endinterface

// File: rtl/cycle_ctrl.sv
// rtl/cycle_ctrl.sv - multi-cycle fetch/decode/exec/mem/wb sequencer for the 9-bit datapath
module cycle_ctrl #(
  parameter int MEM_LAT = 2,
  parameter int CNT_W   = 16
) (
  input  logic        clk,
  input  logic        reset,
  cycle_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  localparam logic [2:0] WAIT_LAST = 3'(MEM_LAT - 1);

  function automatic logic is_branch(input logic [8:0] i);
    return i[8:6] == 3'b101;
  endfunction
  function automatic logic is_mem(input logic [8:0] i);
    return i[8:6] == 3'b110;
  endfunction
  function automatic logic is_halt(input logic [8:0] i);
    return i == 9'h1FF;
  endfunction
  function automatic logic is_clrc(input logic [8:0] i);
    return i == 9'h1C0;
  endfunction
  function automatic logic is_alu(input logic [8:0] i);
    return !(is_branch(i) || is_mem(i) || is_halt(i) || is_clrc(i));
  endfunction

  state_t           state_q, state_d;
  logic [8:0]       ir_q, ir_d;
  logic [2:0]       wait_q, wait_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pc_en_q, pc_en_d, reg_wr_q, reg_wr_d, mem_rd_q, mem_rd_d;
  logic             mem_wr_q, mem_wr_d, flag_en_q, flag_en_d, sc_clr_q, sc_clr_d;
  logic             sc_en_q, sc_en_d, busy_q, busy_d, done_q, done_d;
  logic             br_exec, relj, pc_en;

  // Branch resolution is the only place zero_q reaches an output without a flop.
  assign br_exec = (state_q == S_EXEC) && is_branch(ir_q);
  assign relj    = br_exec && bus.zero_q;
  assign pc_en   = pc_en_q || (br_exec && !bus.zero_q);

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    wait_d  = wait_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE:   if (bus.start) state_d = S_FETCH;
      S_FETCH: begin
        ir_d    = bus.mach_code;
        state_d = S_DECODE;
      end
      S_DECODE: state_d = is_halt(ir_q) ? S_HALT : S_EXEC;
      S_EXEC: begin
        wait_d = 3'd0;
        if (is_mem(ir_q))      state_d = S_MEM;
        else if (is_alu(ir_q)) state_d = S_WB;
        else                   state_d = S_FETCH;
      end
      S_MEM: begin
        if (wait_q == WAIT_LAST) begin
          wait_d  = 3'd0;
          state_d = ir_q[5] ? S_FETCH : S_WB;
        end else begin
          wait_d = wait_q + 3'd1;
        end
      end
      S_WB:     state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IDLE;
    endcase

    if ((pc_en || relj) && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;

    // Outputs are decoded from the next state so they line up with the state they belong to.
    flag_en_d = (state_d == S_EXEC) && is_alu(ir_d);
    sc_en_d   = flag_en_d;
    sc_clr_d  = (state_d == S_EXEC) && is_clrc(ir_d);
    reg_wr_d  = (state_d == S_WB);
    mem_rd_d  = (state_d == S_MEM) && !ir_d[5];
    mem_wr_d  = (state_d == S_MEM) && ir_d[5] && (wait_d == 3'd0);
    pc_en_d   = sc_clr_d || reg_wr_d ||
                ((state_d == S_MEM) && ir_d[5] && (wait_d == WAIT_LAST));
    busy_d    = (state_d != S_IDLE) && (state_d != S_HALT);
    done_d    = (state_d == S_HALT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      ir_q      <= '0;
      wait_q    <= '0;
      cnt_q     <= '0;
      pc_en_q   <= 1'b0;
      reg_wr_q  <= 1'b0;
      mem_rd_q  <= 1'b0;
      mem_wr_q  <= 1'b0;
      flag_en_q <= 1'b0;
      sc_clr_q  <= 1'b0;
      sc_en_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      wait_q    <= wait_d;
      cnt_q     <= cnt_d;
      pc_en_q   <= pc_en_d;
      reg_wr_q  <= reg_wr_d;
      mem_rd_q  <= mem_rd_d;
      mem_wr_q  <= mem_wr_d;
      flag_en_q <= flag_en_d;
      sc_clr_q  <= sc_clr_d;
      sc_en_q   <= sc_en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.ir        = ir_q;
  assign bus.pc_en     = pc_en;
  assign bus.relj      = relj;
  assign bus.reg_wr    = reg_wr_q;
  assign bus.mem_rd    = mem_rd_q;
  assign bus.mem_wr    = mem_wr_q;
  assign bus.flag_en   = flag_en_q;
  assign bus.sc_clr    = sc_clr_q;
  assign bus.sc_en     = sc_en_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.instr_cnt = cnt_q;

endmodule

// File: tb/tb_cycle_ctrl.sv
// tb/tb_cycle_ctrl.sv - directed bench for cycle_ctrl (MEM_LAT=2/CNT_W=16 and MEM_LAT=3/CNT_W=4)
module tb_cycle_ctrl;

  localparam logic [9:0] V_BUSY = 10'h200, V_DONE = 10'h100, V_PC = 10'h080;
  localparam logic [9:0] V_RELJ = 10'h040, V_RW = 10'h020, V_RD = 10'h010;
  localparam logic [9:0] V_WR = 10'h008, V_FL = 10'h004, V_SCE = 10'h002, V_SCC = 10'h001;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  cycle_ctrl_if #(.CNT_W(16)) a ();
  cycle_ctrl_if #(.CNT_W(4))  b ();

  cycle_ctrl #(.MEM_LAT(2), .CNT_W(16)) u_a (.clk(clk), .reset(rst_a), .bus(a.master));
  cycle_ctrl #(.MEM_LAT(3), .CNT_W(4))  u_b (.clk(clk), .reset(rst_b), .bus(b.master));

  wire [9:0] vec_a = {a.busy, a.done, a.pc_en, a.relj, a.reg_wr, a.mem_rd,
                      a.mem_wr, a.flag_en, a.sc_en, a.sc_clr};
  wire [9:0] vec_b = {b.busy, b.done, b.pc_en, b.relj, b.reg_wr, b.mem_rd,
                      b.mem_wr, b.flag_en, b.sc_en, b.sc_clr};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ca(input string tag, input logic [9:0] exp);
    step();
    check(tag, {22'd0, vec_a}, {22'd0, exp});
  endtask

  task automatic cb(input string tag, input logic [9:0] exp);
    step();
    check(tag, {22'd0, vec_b}, {22'd0, exp});
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    a.start = 1'b0; a.mach_code = '0; a.zero_q = 1'b0;
    b.start = 1'b0; b.mach_code = '0; b.zero_q = 1'b0;
    step(); step();
    check("a_rst_vec", {22'd0, vec_a}, 32'd0);
    check("a_rst_ir", {23'd0, a.ir}, 32'd0);
    check("a_rst_cnt", {16'd0, a.instr_cnt}, 32'd0);

    // ALU op: F,D,E,WB
    rst_a = 1'b0; a.start = 1'b1; a.mach_code = 9'b000_01_10_11;
    ca("alu_f", V_BUSY); a.start = 1'b0;
    ca("alu_d", V_BUSY);
    check("alu_ir", {23'd0, a.ir}, 32'h01B);
    ca("alu_e", V_BUSY | V_FL | V_SCE);
    ca("alu_wb", V_BUSY | V_RW | V_PC);
    check("alu_cnt_wb", {16'd0, a.instr_cnt}, 32'd0);

    // Branch taken then not taken
    a.mach_code = 9'b101_000000; a.zero_q = 1'b1;
    ca("brt_f", V_BUSY);
    check("cnt_after_alu", {16'd0, a.instr_cnt}, 32'd1);
    ca("brt_d", V_BUSY);
    ca("brt_e", V_BUSY | V_RELJ);
    ca("brn_f", V_BUSY); a.zero_q = 1'b0;
    check("cnt_after_brt", {16'd0, a.instr_cnt}, 32'd2);
    ca("brn_d", V_BUSY);
    ca("brn_e", V_BUSY | V_PC);

    // Load with MEM_LAT=2
    a.mach_code = 9'b110_010101;
    ca("ld_f", V_BUSY);
    check("cnt_after_brn", {16'd0, a.instr_cnt}, 32'd3);
    ca("ld_d", V_BUSY);
    ca("ld_e", V_BUSY);
    ca("ld_m1", V_BUSY | V_RD);
    ca("ld_m2", V_BUSY | V_RD);
    ca("ld_wb", V_BUSY | V_RW | V_PC);

    // Clear-carry
    a.mach_code = 9'h1C0;
    ca("cc_f", V_BUSY);
    check("cnt_after_ld", {16'd0, a.instr_cnt}, 32'd4);
    ca("cc_d", V_BUSY);
    ca("cc_e", V_BUSY | V_SCC | V_PC);

    // HALT, then start ignored
    a.mach_code = 9'h1FF;
    ca("ah_f", V_BUSY);
    ca("ah_d", V_BUSY);
    ca("ah_1", V_DONE);
    check("ah_cnt", {16'd0, a.instr_cnt}, 32'd5);
    a.start = 1'b1;
    ca("ah_start", V_DONE);
    a.start = 1'b0;
    ca("ah_hold", V_DONE);

    // Second instance: reset state, stores with MEM_LAT=3
    check("b_rst_vec", {22'd0, vec_b}, 32'd0);
    check("b_rst_cnt", {28'd0, b.instr_cnt}, 32'd0);
    rst_b = 1'b0; b.start = 1'b1; b.mach_code = 9'b110_100000;
    cb("st_f", V_BUSY); b.start = 1'b0;
    cb("st_d", V_BUSY);
    cb("st_e", V_BUSY);
    cb("st_m1", V_BUSY | V_WR);
    cb("st_m2", V_BUSY);
    cb("st_m3", V_BUSY | V_PC);
    cb("st2_f", V_BUSY);
    check("cnt_after_st", {28'd0, b.instr_cnt}, 32'd1);
    cb("st2_d", V_BUSY);
    cb("st2_e", V_BUSY);
    cb("st2_m1", V_BUSY | V_WR);
    cb("st2_m2", V_BUSY);
    rst_b = 1'b1;
    cb("st2_rst", 10'h000);
    check("st2_rst_cnt", {28'd0, b.instr_cnt}, 32'd0);
    check("st2_rst_ir", {23'd0, b.ir}, 32'd0);
    rst_b = 1'b0;
    cb("st2_idle", 10'h000);

    // Five ALU ops then HALT
    b.mach_code = 9'b000_01_10_11; b.start = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (i == 1) b.start = 1'b0;
    end
    b.mach_code = 9'h1FF;
    cb("bh_f", V_BUSY);
    check("bh_cnt5", {28'd0, b.instr_cnt}, 32'd5);
    cb("bh_d", V_BUSY);
    cb("bh_1", V_DONE);
    b.start = 1'b1;
    cb("bh_start", V_DONE);
    b.start = 1'b0;
    cb("bh_hold", V_DONE);
    check("bh_cnt_hold", {28'd0, b.instr_cnt}, 32'd5);

    // Twenty ALU ops with a 4-bit counter: saturates at F
    rst_b = 1'b1; step(); rst_b = 1'b0;
    b.mach_code = 9'b000_01_10_11; b.start = 1'b1;
    for (int i = 1; i <= 81; i++) begin
      step();
      if (i == 1) b.start = 1'b0;
      if (i == 57) check("sat_14", {28'd0, b.instr_cnt}, 32'hE);
      if (i == 61) check("sat_15", {28'd0, b.instr_cnt}, 32'hF);
      if (i == 81) check("sat_hold", {28'd0, b.instr_cnt}, 32'hF);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cycle_ctrl.md
# cycle_ctrl

Multi-cycle control sequencer for the 9-bit processor datapath (PC, instruction ROM, register file, ALU, data memory). It steps each instruction through fetch, decode, execute, memory and write-back phases. It generates the per-phase enables for PC advance, relative jump, register write, data-memory access and flag/shift-carry registers. It replaces the all-ones write enable and the PC-compare done of the single-cycle top level, and adds a halt instruction, memory wait states and a retired-instruction counter.

## Interface
- MEM_LAT, 2: data-memory access cycles, legal 1..7
- CNT_W, 16: width of the retired-instruction counter
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high; forces IDLE
- start  in  1  level; sampled only in IDLE, begins execution
- mach_code  in  9  instruction from instr ROM (valid during FETCH)
- zero_q  in  1  registered ALU zero flag
- ir  out  9  latched instruction register
- pc_en  out  1  one-cycle pulse: PC <= PC+1
- relj  out  1  one-cycle pulse: PC <= PC+target (taken branch)
- reg_wr  out  1  register-file write enable
- mem_rd  out  1  data-memory read strobe, held for the access
- mem_wr  out  1  data-memory write enable, single pulse
- flag_en  out  1  load pariQ/zeroQ from ALU
- sc_clr  out  1  clear shift/carry register
- sc_en  out  1  load shift/carry register from ALU
- busy  out  1  high in every state except IDLE and HALT
- done  out  1  high in HALT
- instr_cnt  out  CNT_W  retired instructions, saturating

## Operation
- Decode of ir: op = ir[8:6]. op 3'b101 = branch-if-zero. op 3'b110 = memory (ir[5]=0 load, 1 store). op 3'b111 with ir[5:0]=6'h3F = HALT. op 3'b111 with ir[5:0]=6'h00 = clear-carry. Every other code is an ALU op.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
- IDLE: start=1 -> FETCH, else stay.
- FETCH: ir <= mach_code -> DECODE.
- DECODE: HALT -> HALT. All others -> EXEC.
- EXEC:
  - ALU op: flag_en=1, sc_en=1 -> WB.
  - clear-carry: sc_clr=1, pc_en=1 -> FETCH.
  - branch: relj=1 if zero_q=1, else pc_en=1 -> FETCH.
  - memory: -> MEM.
- MEM:
  - Load: mem_rd=1 for MEM_LAT cycles (wait counter), then -> WB.
  - Store: mem_wr=1 on the first MEM cycle only, remain MEM_LAT cycles, pc_en=1 on the last MEM cycle -> FETCH.
- WB: reg_wr=1, pc_en=1 -> FETCH.
- HALT: done=1, all enables 0. Leave only on reset; start is ignored.
- relj and pc_en are never high in the same cycle. Exactly one of them pulses per retired non-HALT instruction.
- instr_cnt increments in the cycle pc_en or relj pulses. It holds at all-ones once reached, with no wrap. HALT is not counted.

## Timing
- Reset values: state IDLE, ir 0, instr_cnt 0, all other outputs 0. Reset takes effect on the next clk edge, overriding any state including MEM mid-wait. The wait counter clears and no write completes after reset.
- Cycles per instruction, measured from FETCH:
  - ALU: 4 (F,D,E,WB)
  - branch / clear-carry: 3
  - load: 4+MEM_LAT
  - store: 3+MEM_LAT
  - HALT: 2 to reach HALT
- start high in IDLE at edge N: FETCH during cycle N+1; busy rises with it.
- done rises in the cycle after DECODE of HALT and stays high.
- All outputs are registered-state decodes (Moore), with no combinational path from start, mach_code or zero_q to outputs. Exception: relj/pc_en in EXEC of a branch depend on zero_q.
- zero_q is sampled in branch EXEC. An ALU op immediately preceding it has updated zero_q via flag_en at least 2 cycles earlier.

## Test plan
- Reset, then start=1 with ROM word 9'b000_01_10_11 (ALU): sequence F,D,E,WB.
  - flag_en and sc_en pulse in cycle 3; reg_wr and pc_en in cycle 4.
  - instr_cnt=1 after the 4th cycle.
- Branch 9'b101_000000 with zero_q=1: relj pulses in cycle 3 and pc_en stays 0. Repeat with zero_q=0: pc_en pulses and relj stays 0. Both cases take 3 cycles.
- Load 9'b110_0xxxxx with MEM_LAT=2: mem_rd high in cycles 4-5, reg_wr in cycle 6; total 6 cycles.
- Store 9'b110_1xxxxx with MEM_LAT=3:
  - mem_wr high in cycle 4 only; pc_en in cycle 6; reg_wr never asserted.
  - Assert reset during cycle 5 of a second store: next cycle is IDLE, all outputs 0, instr_cnt 0.
- HALT 9'h1FF after 5 ALU ops:
  - done=1 and busy=0 from the cycle after its DECODE; instr_cnt=5.
  - Pulse start again: state remains HALT.
- CNT_W=4, run 20 ALU ops: instr_cnt reaches 4'hF and holds at 4'hF.
